// File: rtl/sipo_deser_if.sv
// Handshake/bus bundle for sipo_deser: serial input side, word output side and status.
// The master modport belongs to whoever drives the serial line and consumes words.
interface sipo_deser_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) ();
  logic             init;
  logic             si;
  logic             si_valid;
  logic             msb_first;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] bit_cnt;
  logic             last_bit;
  logic             overrun;

  modport master (
    output init, si, si_valid, msb_first, out_ready,
    input  out_valid, out_data, bit_cnt, last_bit, overrun
  );

  modport slave (
    input  init, si, si_valid, msb_first, out_ready,
    output out_valid, out_data, bit_cnt, last_bit, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: bit counter, per-word bit order and a
// one-entry valid/ready output register with sticky overrun flag.
module sipo_deser #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  sipo_deser_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_order;
  logic             r_valid;
  logic             r_ovr;

  logic             w_order;
  logic             w_last;
  logic             w_done;
  logic [WIDTH-1:0] w_sh_nxt;

  // Bit order is sampled on the first bit of a word and frozen for the rest.
  assign w_order  = (r_cnt == '0) ? bus.msb_first : r_order;
  assign w_sh_nxt = w_order ? {r_sh[WIDTH-2:0], bus.si} : {bus.si, r_sh[WIDTH-1:1]};
  assign w_last   = bus.si_valid && (r_cnt == LAST);
  assign w_done   = w_last && !bus.init;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_order <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (bus.init) begin
        r_sh    <= '0;
        r_cnt   <= '0;
        r_order <= 1'b0;
        r_ovr   <= 1'b0;
      end else if (bus.si_valid) begin
        r_order <= w_order;
        if (w_last) begin
          r_sh  <= '0;
          r_cnt <= '0;
          if (r_valid && !bus.out_ready) begin
            r_ovr <= 1'b1;
          end
        end else begin
          r_sh  <= w_sh_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
      end

      // A completion on the consume edge keeps the buffer full with the new word.
      if (w_done) begin
        r_data  <= w_sh_nxt;
        r_valid <= 1'b1;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.bit_cnt   = r_cnt;
  assign bus.last_bit  = w_last;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=8): stimulus pushes expected words into a
// scoreboard queue, a monitor pops and compares on every word completion.
module tb_sipo_deser;

  logic clk;
  logic rst_n;

  sipo_deser_if #(.WIDTH(8)) bus ();

  sipo_deser #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total;
  int n_pass;
  int cyc;
  int prev_pop_cyc;
  int last_pop_cyc;
  logic [7:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  // Monitor: detect a completion just before the edge, check the word just after it.
  initial begin
    logic       pend;
    logic [7:0] exp;
    prev_pop_cyc = 0;
    last_pop_cyc = 0;
    forever begin
      @(negedge clk);
      #4;
      pend = bus.last_bit && !bus.init && rst_n;
      @(posedge clk);
      #1;
      if (pend) begin
        if (sb.size() == 0) begin
          n_total = n_total + 1;
          $display("FAIL sb_unexpected_word: got %0h expected none", bus.out_data);
        end else begin
          exp = sb.pop_front();
          chk("sb_out_data", {24'd0, bus.out_data}, {24'd0, exp});
          chk("sb_out_valid", {31'd0, bus.out_valid}, 32'd1);
          prev_pop_cyc = last_pop_cyc;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  // seq[i] is the i-th bit sent; toggle_at >= 0 flips msb_first from that bit on.
  task automatic send_word(input logic [7:0] seq, input logic ord, input int toggle_at,
                           input logic [7:0] exp, input bit gaps, input bit idle_after);
    int g;
    sb.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge clk);
          bus.si_valid  = 1'b0;
          bus.si        = 1'($urandom);
          bus.msb_first = 1'($urandom);
        end
      end
      @(negedge clk);
      bus.si        = seq[i];
      bus.si_valid  = 1'b1;
      bus.msb_first = (toggle_at >= 0 && i >= toggle_at) ? ~ord : ord;
      #3;
      chk("bit_cnt_run", {24'd0, bus.bit_cnt}, i);
      chk("last_bit", {31'd0, bus.last_bit}, (i == 7) ? 32'd1 : 32'd0);
      if (i == 7) begin
        @(posedge clk);
        #1;
        chk("bit_cnt_wrap", {24'd0, bus.bit_cnt}, 32'd0);
        chk("out_valid_done", {31'd0, bus.out_valid}, 32'd1);
      end
    end
    if (idle_after) begin
      @(negedge clk);
      bus.si_valid = 1'b0;
    end
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.si        = 1'($urandom);
      bus.si_valid  = 1'b1;
      bus.msb_first = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n         = 1'b0;
    bus.init      = 1'b0;
    bus.si        = 1'b0;
    bus.si_valid  = 1'b0;
    bus.msb_first = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_bit_cnt", {24'd0, bus.bit_cnt}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LSB-first word 1,0,1,1,0,0,1,0 -> 8'h4D, held because out_ready is low
    send_word(8'h4D, 1'b0, -1, 8'h4D, 1'b0, 1'b1);
    chk("held_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consume_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("consume_data_hold", {24'd0, bus.out_data}, 32'h4D);

    // MSB-first at bit 0, msb_first toggled at bit 3 must be ignored -> 8'hB2
    send_word(8'h4D, 1'b1, 3, 8'hB2, 1'b0, 1'b1);

    // Random gaps do not alter the word
    send_word(8'h4D, 1'b0, -1, 8'h4D, 1'b1, 1'b1);

    // Back-to-back words with out_ready held high
    @(negedge clk);
    send_word(8'h3C, 1'b0, -1, 8'h3C, 1'b0, 1'b0);
    send_word(8'h4D, 1'b0, -1, 8'h4D, 1'b0, 1'b1);
    chk("b2b_spacing", last_pop_cyc - prev_pop_cyc, 32'd8);
    chk("b2b_overrun", {31'd0, bus.overrun}, 32'd0);

    // Overrun: two words with out_ready low
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b0;
    send_word(8'h4D, 1'b0, -1, 8'h4D, 1'b0, 1'b1);
    chk("ovr_first", {31'd0, bus.overrun}, 32'd0);
    send_word(8'h3C, 1'b0, -1, 8'h3C, 1'b0, 1'b1);
    chk("ovr_set", {31'd0, bus.overrun}, 32'd1);
    chk("ovr_data", {24'd0, bus.out_data}, 32'h3C);
    bus.init = 1'b1;
    @(posedge clk);
    #1;
    chk("init_ovr_clear", {31'd0, bus.overrun}, 32'd0);
    chk("init_keeps_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("init_keeps_data", {24'd0, bus.out_data}, 32'h3C);
    @(negedge clk);
    bus.init = 1'b0;

    // Init mid-word: 5 bits, then init together with a valid bit
    bus.out_ready = 1'b1;
    send_bits(5);
    @(negedge clk);
    chk("pre_init_cnt", {24'd0, bus.bit_cnt}, 32'd5);
    bus.init     = 1'b1;
    bus.si_valid = 1'b1;
    bus.si       = 1'b1;
    @(posedge clk);
    #1;
    chk("init_cnt_clear", {24'd0, bus.bit_cnt}, 32'd0);
    @(negedge clk);
    bus.init     = 1'b0;
    bus.si_valid = 1'b0;
    send_word(8'hA5, 1'b0, -1, 8'hA5, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle with a held word and a partial word
    bus.out_ready = 1'b0;
    send_word(8'h3C, 1'b0, -1, 8'h3C, 1'b0, 1'b0);
    send_bits(3);
    @(negedge clk);
    bus.si_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("arst_bit_cnt", {24'd0, bus.bit_cnt}, 32'd0);
    chk("arst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("arst_last_bit", {31'd0, bus.last_bit}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cnt", {24'd0, bus.bit_cnt}, 32'd0);
    send_word(8'h4D, 1'b0, -1, 8'h4D, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserializer with a built-in bit counter, per-word bit-order selection and a valid/ready output holding register. Serial bits are qualified by `si_valid`. Every WIDTH accepted bits form a word, which is handed to a downstream consumer through a one-entry output buffer. Words that arrive while the buffer is still full are flagged as overrun. The block sits between a serial line front-end and the parallel datapath, and replaces the fixed 8-bit shifter/3-bit counter pairs used there.

## Interface
- `WIDTH`, default 8: word width in bits. Must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: bit-counter width. Derived; do not override.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `init`  in  1  synchronous clear of word assembly state.
- `si`  in  1  serial data bit.
- `si_valid`  in  1  `si` is accepted on this edge.
- `msb_first`  in  1  bit order: 1 = first bit lands in MSB, 0 = first bit lands in LSB.
- `out_ready`  in  1  consumer accepts `out_data` on this edge.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_data`  out  WIDTH  assembled word.
- `bit_cnt`  out  CNT_W  bits accepted in the current word (0..WIDTH-1).
- `last_bit`  out  1  combinational: `si_valid && bit_cnt == WIDTH-1`.
- `overrun`  out  1  sticky: a completed word was lost.

## Operation
- **Reset (`rst_n`=0).** The shift register, `bit_cnt`, `out_data`, `out_valid`, `overrun` and the latched order bit all clear to 0, immediately and independently of `clk`.
- **`init`=1.**
  - Clears the shift register, `bit_cnt`, `overrun` and the latched order bit.
  - `init` has priority over `si_valid`.
  - `out_valid` and `out_data` are not affected; an already completed word stays deliverable.
- **Bit acceptance (`si_valid`=1, `init`=0).**
  - When `bit_cnt`==0, `msb_first` is latched as the order for the whole word.
  - While `bit_cnt`≠0, the latched value is used and `msb_first` changes have no effect.
  - LSB-first shift: `sh <= {si, sh[WIDTH-1:1]}`.
  - MSB-first shift: `sh <= {sh[WIDTH-2:0], si}`.
  - `bit_cnt` increments by 1. From WIDTH-1 it wraps to 0.
- **Word completion.** On the edge where `last_bit`=1:
  - The completed word (shift register with the current `si` applied) loads directly into `out_data`.
  - `out_valid` is set to 1.
  - The shift register clears.
- **Handshake.**
  - A word is consumed on any edge with `out_valid && out_ready`.
  - `out_valid` then drops, unless a new word completes on the same edge.
  - `out_data` holds its value until the next completion; it is not cleared on consume.
- **Completion with `out_valid`=1 and `out_ready`=1.** The new word loads, `out_valid` stays 1, and `overrun` is unchanged.
- **Completion with `out_valid`=1 and `out_ready`=0.** The new word overwrites `out_data`, `out_valid` stays 1, and `overrun` is set. It stays set until `init` or reset.
- **`si_valid`=0.** No state change except the output handshake.

## Timing
- Latency: `out_valid` and `out_data` update on the same rising edge that samples the WIDTH-th valid bit. There is no extra pipeline cycle.
- Throughput: one bit per cycle. Back-to-back words need no idle cycle; bit 0 of the next word may be accepted on the edge after completion.
- `out_ready` may be asserted before `out_valid`. It has no effect while `out_valid`=0.
- `last_bit` is purely combinational from `si_valid` and `bit_cnt`. It must not depend on `out_ready`.
- Reset asserted mid-word discards the partial word and any held word. The first valid bit after `rst_n` rises is bit 0 of a new word.

## Test plan
- **Reset.** Drive `rst_n`=0 asynchronously mid-cycle, with random state beforehand. All outputs must read 0 before the next clock edge, and `bit_cnt`=0 after release.
- **LSB-first word.** WIDTH=8, `msb_first`=0, bits 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles.
  - `last_bit`=1 in cycle 8.
  - After edge 8: `out_data`=8'h4D, `out_valid`=1, `bit_cnt`=0.
- **MSB-first and mid-word order change.** Same bit sequence with `msb_first`=1 at bit 0, then toggled to 0 at bit 3. Result must be `out_data`=8'hB2.
- **Gaps and back-to-back.**
  - Insert random `si_valid`=0 gaps; the word must be unchanged (8'h4D).
  - Send two words back-to-back with `out_ready`=1 held: second word visible exactly 8 valid edges after the first, `out_valid` continuously 1, `overrun`=0.
- **Overrun.** Hold `out_ready`=0 and send words 8'h4D then 8'h3C.
  - `out_data`=8'h3C, `overrun`=1.
  - A later `init` clears `overrun` and leaves `out_valid`=1.
- **Init mid-word.** Send 5 bits, pulse `init` together with `si_valid`=1.
  - `bit_cnt`=0 and the bit is not taken.
  - The next 8 bits form a clean word.
